// File: rtl/mem_access_unit.sv
// Memory-access stage: one load/store at a time over a valid/ready data bus, results pulsed to writeback.
// Optional MEM_MISALIGN_CHECK_EN traps misaligned LH/LHU/SH/LW/SW locally and sends no bus request.
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [3:0]        mem_op_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic              wsel_i,
  input  logic              wena_i,
  input  logic [4:0]        waddr_i,
  input  logic              csr_wena_i,
  input  logic [31:0]       csr_waddr_i,
  input  logic [31:0]       csr_wdata_i,
  output logic              dmem_req_valid_o,
  input  logic              dmem_req_ready_i,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic              dmem_wen_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  output logic [3:0]        dmem_wstrb_o,
  input  logic              dmem_resp_valid_i,
  input  logic [DATA_W-1:0] dmem_resp_rdata_i,
  output logic              we_o,
  output logic              wsel_o,
  output logic              wena_o,
  output logic [4:0]        waddr_o,
  output logic [DATA_W-1:0] alu_result_o,
  output logic [DATA_W-1:0] mem_result_o,
  output logic              csr_wena_o,
  output logic [31:0]       csr_waddr_o,
  output logic [31:0]       csr_wdata_o,
  output logic              misalign_o
);
  localparam logic [3:0] OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3, OP_LBU = 4'd4, OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB = 4'd9, OP_SH = 4'd10, OP_SW = 4'd11;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

  state_t            r_state;
  logic [3:0]        r_op;
  logic [1:0]        r_lo;
  logic              r_req_valid, r_wen, r_we, r_wsel, r_wena, r_csr_wena, r_misalign;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_alu, r_mem;
  logic [3:0]        r_wstrb;
  logic [4:0]        r_waddr;
  logic [31:0]       r_csr_waddr, r_csr_wdata;

  logic              w_is_mem, w_misalign;
  logic [3:0]        w_wstrb;
  logic [DATA_W-1:0] w_wdata, w_load_data;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;

  always_comb begin
    w_is_mem = 1'b0;
    w_wstrb  = 4'b0000;
    w_wdata  = store_data_i;
    case (mem_op_i)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: w_is_mem = 1'b1;
      OP_SB: begin
        w_is_mem = 1'b1;
        w_wstrb  = 4'b0001 << alu_result_i[1:0];
        w_wdata  = {4{store_data_i[7:0]}};
      end
      OP_SH: begin
        w_is_mem = 1'b1;
        w_wstrb  = 4'b0011 << {alu_result_i[1], 1'b0};
        w_wdata  = {2{store_data_i[15:0]}};
      end
      OP_SW: begin
        w_is_mem = 1'b1;
        w_wstrb  = 4'b1111;
      end
      default: w_is_mem = 1'b0;
    endcase
  end

`ifdef MEM_MISALIGN_CHECK_EN
  always_comb begin
    w_misalign = 1'b0;
    case (mem_op_i)
      OP_LH, OP_LHU, OP_SH: w_misalign = alu_result_i[0];
      OP_LW, OP_SW:         w_misalign = (alu_result_i[1:0] != 2'b00);
      default:              w_misalign = 1'b0;
    endcase
  end
`else
  assign w_misalign = 1'b0;
`endif

  // Lane selection uses the low address bits captured at accept time
  assign w_byte = dmem_resp_rdata_i[{r_lo, 3'b000} +: 8];
  assign w_half = r_lo[1] ? dmem_resp_rdata_i[31:16] : dmem_resp_rdata_i[15:0];

  always_comb begin
    case (r_op)
      OP_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_load_data = {24'd0, w_byte};
      OP_LH:   w_load_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_load_data = {16'd0, w_half};
      OP_LW:   w_load_data = dmem_resp_rdata_i;
      default: w_load_data = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_lo        <= '0;
      r_req_valid <= 1'b0;
      r_wen       <= 1'b0;
      r_we        <= 1'b0;
      r_wsel      <= 1'b0;
      r_wena      <= 1'b0;
      r_csr_wena  <= 1'b0;
      r_misalign  <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_alu       <= '0;
      r_mem       <= '0;
      r_wstrb     <= '0;
      r_waddr     <= '0;
      r_csr_waddr <= '0;
      r_csr_wdata <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (valid_i) begin
            r_op        <= mem_op_i;
            r_lo        <= alu_result_i[1:0];
            r_wsel      <= wsel_i;
            r_wena      <= wena_i & ~w_misalign;
            r_waddr     <= waddr_i;
            r_alu       <= alu_result_i;
            r_mem       <= '0;
            r_csr_wena  <= csr_wena_i;
            r_csr_waddr <= csr_waddr_i;
            r_csr_wdata <= csr_wdata_i;
            r_misalign  <= w_misalign;
            if (w_is_mem && !w_misalign) begin
              r_req_valid <= 1'b1;
              r_addr      <= {alu_result_i[ADDR_W-1:2], 2'b00};
              r_wen       <= mem_op_i[3];
              r_wdata     <= w_wdata;
              r_wstrb     <= w_wstrb;
              r_state     <= S_REQ;
            end else begin
              r_we    <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_REQ: begin
          if (dmem_req_ready_i) begin
            r_req_valid <= 1'b0;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          // Stores get w_load_data = 0 here, so mem_result stays 0 for them
          if (dmem_resp_valid_i) begin
            r_mem   <= w_load_data;
            r_we    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready_o          = (r_state == S_IDLE);
  assign dmem_req_valid_o = r_req_valid;
  assign dmem_addr_o      = r_addr;
  assign dmem_wen_o       = r_wen;
  assign dmem_wdata_o     = r_wdata;
  assign dmem_wstrb_o     = r_wstrb;
  assign we_o             = r_we;
  assign wsel_o           = r_wsel;
  assign wena_o           = r_wena;
  assign waddr_o          = r_waddr;
  assign alu_result_o     = r_alu;
  assign mem_result_o     = r_mem;
  assign csr_wena_o       = r_csr_wena;
  assign csr_waddr_o      = r_csr_waddr;
  assign csr_wdata_o      = r_csr_wdata;
  assign misalign_o       = r_misalign;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus random ops against an arithmetic reference model.
// Define MEM_MISALIGN_CHECK_EN for both files to exercise the misaligned-access trap.
module tb_mem_access_unit;
  logic        clock = 1'b0, reset = 1'b1;
  logic        valid_i = 0, ready_o;
  logic [3:0]  mem_op_i = 0;
  logic [31:0] alu_result_i = 0, store_data_i = 0;
  logic        wsel_i = 0, wena_i = 0, csr_wena_i = 0;
  logic [4:0]  waddr_i = 0;
  logic [31:0] csr_waddr_i = 0, csr_wdata_i = 0;
  logic        dmem_req_valid_o, dmem_req_ready_i = 0, dmem_wen_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_wstrb_o;
  logic        dmem_resp_valid_i = 0;
  logic [31:0] dmem_resp_rdata_i = 0;
  logic        we_o, wsel_o, wena_o, csr_wena_o, misalign_o;
  logic [4:0]  waddr_o;
  logic [31:0] alu_result_o, mem_result_o, csr_waddr_o, csr_wdata_o;

  int checks = 0, errors = 0;

  // observations from the last do_op
  int          obs_lat;
  bit          obs_acc_rdy, obs_ready_bad, obs_req_seen, obs_unstable, obs_req_after_hs, obs_we2, obs_rdy2;
  logic [68:0] obs_req;
  logic [71:0] obs_pass;
  logic [31:0] obs_alu, obs_mem;
  logic        obs_mis;
  logic [71:0] drv_pass;

  mem_access_unit dut (
    .clock(clock), .reset(reset), .valid_i(valid_i), .ready_o(ready_o), .mem_op_i(mem_op_i),
    .alu_result_i(alu_result_i), .store_data_i(store_data_i), .wsel_i(wsel_i), .wena_i(wena_i),
    .waddr_i(waddr_i), .csr_wena_i(csr_wena_i), .csr_waddr_i(csr_waddr_i), .csr_wdata_i(csr_wdata_i),
    .dmem_req_valid_o(dmem_req_valid_o), .dmem_req_ready_i(dmem_req_ready_i), .dmem_addr_o(dmem_addr_o),
    .dmem_wen_o(dmem_wen_o), .dmem_wdata_o(dmem_wdata_o), .dmem_wstrb_o(dmem_wstrb_o),
    .dmem_resp_valid_i(dmem_resp_valid_i), .dmem_resp_rdata_i(dmem_resp_rdata_i), .we_o(we_o),
    .wsel_o(wsel_o), .wena_o(wena_o), .waddr_o(waddr_o), .alu_result_o(alu_result_o),
    .mem_result_o(mem_result_o), .csr_wena_o(csr_wena_o), .csr_waddr_o(csr_waddr_o),
    .csr_wdata_o(csr_wdata_o), .misalign_o(misalign_o)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic bit m_load(input logic [3:0] op);
    return op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
  endfunction
  function automatic bit m_store(input logic [3:0] op);
    return op inside {4'd9, 4'd10, 4'd11};
  endfunction
  function automatic int m_size(input logic [3:0] op);
    if (op inside {4'd1, 4'd4, 4'd9}) return 1;
    if (op inside {4'd2, 4'd5, 4'd10}) return 2;
    return 4;
  endfunction
  function automatic bit m_mis(input logic [3:0] op, input logic [31:0] a);
`ifdef MEM_MISALIGN_CHECK_EN
    return (m_load(op) || m_store(op)) && ((a % m_size(op)) != 0);
`else
    return 1'b0;
`endif
  endfunction
  function automatic int m_off(input logic [3:0] op, input logic [31:0] a);
    return ((a % 4) / m_size(op)) * m_size(op);
  endfunction
  function automatic logic [31:0] m_load_val(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rd);
    longint v, span;
    if (!m_load(op)) return 32'd0;
    span = longint'(1) << (8 * m_size(op));
    v = (longint'(rd) >> (8 * m_off(op, a))) % span;
    if ((op == 4'd1 || op == 4'd2) && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction
  function automatic logic [3:0] m_strb(input logic [3:0] op, input logic [31:0] a);
    int s = m_size(op);
    int v = ((1 << s) - 1) << m_off(op, a);
    return v[3:0];
  endfunction
  function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] sd);
    longint lane, w;
    int s = m_size(op);
    lane = longint'(sd) % (longint'(1) << (8 * s));
    w = 0;
    for (int k = 0; k < 4; k += s) w = w + (lane << (8 * k));
    return w[31:0];
  endfunction

  // ---------------- driver / bus responder ----------------
  task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                       input logic [31:0] rd, input int stall, input int delay, input bit hold,
                       input logic wena_v, input logic [4:0] waddr_v);
    int req_cnt = 0, resp_cnt = 0;
    bit hs = 0;
    @(negedge clock);
    mem_op_i = op; alu_result_i = addr; store_data_i = sd;
    wsel_i = 1'($urandom); wena_i = wena_v; waddr_i = waddr_v;
    csr_wena_i = 1'($urandom); csr_waddr_i = $urandom; csr_wdata_i = $urandom;
    drv_pass = {wsel_i, wena_i & ~m_mis(op, addr), waddr_i, csr_wena_i, csr_waddr_i, csr_wdata_i};
    valid_i = 1'b1;
    obs_acc_rdy = ready_o;
    obs_lat = 0; obs_ready_bad = 0; obs_req_seen = 0; obs_unstable = 0; obs_req_after_hs = 0;
    obs_req = '0;
    @(posedge clock); #1;
    if (!hold) valid_i = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clock);
      dmem_req_ready_i = 1'b0; dmem_resp_valid_i = 1'b0; dmem_resp_rdata_i = $urandom;
      if (ready_o) obs_ready_bad = 1;
      if (we_o) begin
        obs_lat = c;
        obs_pass = {wsel_o, wena_o, waddr_o, csr_wena_o, csr_waddr_o, csr_wdata_o};
        obs_alu = alu_result_o; obs_mem = mem_result_o; obs_mis = misalign_o;
        break;
      end
      if (dmem_req_valid_o) begin
        if (hs) obs_req_after_hs = 1;
        if (obs_req_seen && obs_req !== {dmem_addr_o, dmem_wen_o, dmem_wdata_o, dmem_wstrb_o}) obs_unstable = 1;
        obs_req = {dmem_addr_o, dmem_wen_o, dmem_wdata_o, dmem_wstrb_o};
        obs_req_seen = 1;
        // random stray responses while the request is pending must be ignored
        dmem_resp_valid_i = 1'($urandom);
        if (req_cnt >= stall) begin dmem_req_ready_i = 1'b1; hs = 1; end
        req_cnt++;
      end else if (hs) begin
        if (resp_cnt >= delay) begin dmem_resp_valid_i = 1'b1; dmem_resp_rdata_i = rd; end
        resp_cnt++;
      end
    end
    @(negedge clock);
    dmem_req_ready_i = 1'b0; dmem_resp_valid_i = 1'b0;
    obs_we2 = we_o; obs_rdy2 = ready_o;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    @(negedge clock);
    checks++;
    if ({we_o, dmem_req_valid_o, dmem_addr_o, dmem_wen_o, dmem_wdata_o, dmem_wstrb_o, wsel_o, wena_o, waddr_o,
         alu_result_o, mem_result_o, csr_wena_o, csr_waddr_o, csr_wdata_o, misalign_o} !== '0) begin
      errors++; $display("FAIL reset_outputs: some output nonzero after reset (we=%b req=%b alu=%h)", we_o, dmem_req_valid_o, alu_result_o);
    end
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
  endtask

  task automatic test_nonmem;
    do_op(4'd0, 32'h12345678, 32'h0, 32'h0, 0, 0, 0, 1'b1, 5'd5);
    checks++; if (obs_lat !== 1) begin errors++; $display("FAIL nonmem_latency: got %0d expected 1", obs_lat); end
    checks++; if (obs_alu !== 32'h12345678) begin errors++; $display("FAIL nonmem_alu: got %h expected 12345678", obs_alu); end
    checks++; if (obs_mem !== 32'h0) begin errors++; $display("FAIL nonmem_mem_result: got %h expected 0", obs_mem); end
    checks++; if (obs_req_seen !== 1'b0) begin errors++; $display("FAIL nonmem_no_request: request seen=%b expected 0", obs_req_seen); end
    checks++; if (obs_pass[70:65] !== {1'b1, 5'd5}) begin errors++; $display("FAIL nonmem_wena_waddr: got %b expected 100101", obs_pass[70:65]); end
  endtask

  task automatic test_lb;
    do_op(4'd1, 32'h80000003, 32'h0, 32'h80FF0000, 0, 0, 0, 1'b1, 5'd7);
    checks++; if (obs_req[68:37] !== 32'h80000000) begin errors++; $display("FAIL lb_addr: got %h expected 80000000", obs_req[68:37]); end
    checks++; if (obs_mem !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_sext: got %h expected ffffff80", obs_mem); end
    checks++; if (obs_lat !== 3) begin errors++; $display("FAIL lb_latency: got %0d expected 3", obs_lat); end
    do_op(4'd4, 32'h80000003, 32'h0, 32'h80FF0000, 0, 0, 0, 1'b1, 5'd7);
    checks++; if (obs_mem !== 32'h00000080) begin errors++; $display("FAIL lbu_zext: got %h expected 00000080", obs_mem); end
  endtask

  task automatic test_sh_stall;
    do_op(4'd10, 32'h80000006, 32'hAAAA1234, 32'hDEADBEEF, 3, 0, 0, 1'b0, 5'd0);
    checks++; if (obs_unstable !== 1'b0) begin errors++; $display("FAIL sh_stable: request changed while stalled"); end
    checks++;
    if (obs_req !== {32'h80000004, 1'b1, 32'h12341234, 4'b1100}) begin
      errors++; $display("FAIL sh_request: got %h expected %h", obs_req, {32'h80000004, 1'b1, 32'h12341234, 4'b1100});
    end
    checks++; if (obs_lat !== 6) begin errors++; $display("FAIL sh_latency: got %0d expected 6", obs_lat); end
    checks++; if (obs_mem !== 32'h0) begin errors++; $display("FAIL sh_mem_result: got %h expected 0", obs_mem); end
  endtask

  task automatic test_back_to_back;
    do_op(4'd3, 32'h80000010, 32'h0, 32'h13579BDF, 0, 5, 1, 1'b1, 5'd3);
    checks++; if (obs_ready_bad !== 1'b0) begin errors++; $display("FAIL b2b_ready_busy: ready_o high while busy"); end
    checks++; if (obs_lat !== 8) begin errors++; $display("FAIL b2b_latency: got %0d expected 8", obs_lat); end
    checks++; if (obs_mem !== 32'h13579BDF) begin errors++; $display("FAIL b2b_lw_data: got %h expected 13579bdf", obs_mem); end
    checks++; if ({obs_we2, obs_rdy2} !== 2'b01) begin errors++; $display("FAIL b2b_idle_gap: we/ready got %b%b expected 01", obs_we2, obs_rdy2); end
    mem_op_i = 4'd0; alu_result_i = 32'hCAFEF00D;
    @(posedge clock); #1 valid_i = 1'b0;
    @(negedge clock);
    checks++;
    if ({we_o, alu_result_o} !== {1'b1, 32'hCAFEF00D}) begin
      errors++; $display("FAIL b2b_second: we=%b alu=%h expected we=1 alu=cafef00d", we_o, alu_result_o);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_in_resp;
    bit we_seen = 0;
    @(negedge clock);
    mem_op_i = 4'd3; alu_result_i = 32'h80000020; wena_i = 1'b1; valid_i = 1'b1;
    @(posedge clock); #1 valid_i = 1'b0;
    @(negedge clock); dmem_req_ready_i = 1'b1;
    @(negedge clock); dmem_req_ready_i = 1'b0; reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock); dmem_resp_valid_i = 1'b1; dmem_resp_rdata_i = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (we_o) we_seen = 1;
    end
    dmem_resp_valid_i = 1'b0;
    checks++; if (we_seen !== 1'b0) begin errors++; $display("FAIL rst_resp_no_we: we_o pulsed after aborted access"); end
    checks++;
    if ({dmem_req_valid_o, dmem_addr_o, mem_result_o, alu_result_o, wena_o} !== '0) begin
      errors++; $display("FAIL rst_resp_outputs: req=%b addr=%h mem=%h expected all 0", dmem_req_valid_o, dmem_addr_o, mem_result_o);
    end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rst_resp_ready: got %b expected 1", ready_o); end
  endtask

`ifdef MEM_MISALIGN_CHECK_EN
  task automatic test_misalign;
    do_op(4'd3, 32'h80000002, 32'h0, 32'h0, 0, 0, 0, 1'b1, 5'd9);
    checks++; if (obs_req_seen !== 1'b0) begin errors++; $display("FAIL mis_no_request: request seen=%b expected 0", obs_req_seen); end
    checks++;
    if ({obs_lat == 1, obs_mis, obs_pass[70]} !== 3'b110) begin
      errors++; $display("FAIL mis_flags: lat=%0d misalign=%b wena=%b expected 1/1/0", obs_lat, obs_mis, obs_pass[70]);
    end
  endtask
`endif

  task automatic test_random;
    logic [3:0] ops [11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9, 4'd10, 4'd11, 4'd6, 4'd15};
    for (int n = 0; n < 60; n++) begin
      logic [3:0]  op = ops[$urandom_range(0, 10)];
      logic [31:0] a  = 32'h80000000 | $urandom_range(0, 255);
      logic [31:0] sd = $urandom, rd = $urandom;
      int st = $urandom_range(0, 3), dl = $urandom_range(0, 3);
      bit issue = (m_load(op) || m_store(op)) && !m_mis(op, a);
      int exp_lat = issue ? 3 + st + dl : 1;
      do_op(op, a, sd, rd, st, dl, 0, 1'($urandom), 5'($urandom));
      checks++; if (obs_acc_rdy !== 1'b1) begin errors++; $display("FAIL rnd_accept_ready op=%0d: got 0 expected 1", op); end
      checks++; if (obs_lat !== exp_lat) begin errors++; $display("FAIL rnd_latency op=%0d addr=%h: got %0d expected %0d", op, a, obs_lat, exp_lat); end
      checks++; if ({obs_we2, obs_rdy2, obs_ready_bad} !== 3'b010) begin errors++; $display("FAIL rnd_handshake op=%0d: we2/rdy2/busy_rdy got %b%b%b expected 010", op, obs_we2, obs_rdy2, obs_ready_bad); end
      checks++; if (obs_pass !== drv_pass) begin errors++; $display("FAIL rnd_passthrough op=%0d: got %h expected %h", op, obs_pass, drv_pass); end
      checks++; if (obs_alu !== a) begin errors++; $display("FAIL rnd_alu op=%0d: got %h expected %h", op, obs_alu, a); end
      checks++; if (obs_mem !== m_load_val(op, a, rd)) begin errors++; $display("FAIL rnd_mem_result op=%0d addr=%h rd=%h: got %h expected %h", op, a, rd, obs_mem, m_load_val(op, a, rd)); end
      checks++; if (obs_mis !== m_mis(op, a)) begin errors++; $display("FAIL rnd_misalign op=%0d addr=%h: got %b expected %b", op, a, obs_mis, m_mis(op, a)); end
      checks++; if (obs_req_seen !== issue) begin errors++; $display("FAIL rnd_issue op=%0d addr=%h: got %b expected %b", op, a, obs_req_seen, issue); end
      if (issue) begin
        logic [68:0] exp_req = {a & 32'hFFFFFFFC, m_store(op), m_store(op) ? m_wdata(op, sd) : sd,
                                m_store(op) ? m_strb(op, a) : 4'b0000};
        checks++;
        if (m_store(op) ? (obs_req !== exp_req) : (obs_req[68:36] !== exp_req[68:36])) begin
          errors++; $display("FAIL rnd_request op=%0d addr=%h: got %h expected %h", op, a, obs_req, exp_req);
        end
        checks++;
        if ({obs_unstable, obs_req_after_hs} !== 2'b00) begin
          errors++; $display("FAIL rnd_req_hold op=%0d: unstable=%b after_handshake=%b expected 00", op, obs_unstable, obs_req_after_hs);
        end
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    test_reset();
    test_nonmem();
    test_lb();
    test_sh_stall();
    test_back_to_back();
    test_reset_in_resp();
`ifdef MEM_MISALIGN_CHECK_EN
    test_misalign();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-access stage of the NPC core. Sits between execute and the writeback register.
- Accepts one instruction at a time from execute and performs the load/store on the data-memory request/response bus.
- Aligns and sign/zero-extends load data.
- Presents ALU result, memory result and CSR write info to writeback with a one-cycle write-enable pulse.

Parameters:
- ADDR_W, 32, data-memory address width.
- DATA_W, 32, data width; the byte-lane logic is defined only for 32.

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high
- valid_i  in  1  execute presents an instruction
- ready_o  out  1  unit accepts (high only in IDLE)
- mem_op_i  in  4  0=none, 1=LB, 2=LH, 3=LW, 4=LBU, 5=LHU, 9=SB, 10=SH, 11=SW; other codes treated as none
- alu_result_i  in  32  ALU result / effective address
- store_data_i  in  32  rs2 data for stores
- wsel_i  in  1  writeback source select (passthrough)
- wena_i  in  1  GPR write enable
- waddr_i  in  5  GPR index
- csr_wena_i  in  1  CSR write enable
- csr_waddr_i  in  32  CSR address
- csr_wdata_i  in  32  CSR data
- dmem_req_valid_o  out  1  bus request valid
- dmem_req_ready_i  in  1  bus accepts request
- dmem_addr_o  out  32  word-aligned address
- dmem_wen_o  out  1  1=write
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_wstrb_o  out  4  byte strobes
- dmem_resp_valid_i  in  1  read data / write ack valid
- dmem_resp_rdata_i  in  32  read data
- we_o  out  1  one-cycle writeback strobe
- wsel_o  out  1  captured wsel_i
- wena_o  out  1  captured wena_i
- waddr_o  out  5  captured waddr_i
- alu_result_o  out  32  captured alu_result_i
- mem_result_o  out  32  extended load data; 0 for non-loads
- csr_wena_o  out  1  captured csr_wena_i
- csr_waddr_o  out  32  captured csr_waddr_i
- csr_wdata_o  out  32  captured csr_wdata_i
- misalign_o  out  1  misaligned-access flag, valid with we_o

Behaviour:
- Clock is clock; reset is synchronous, active-high.
- Reset: state=IDLE. All registered outputs and dmem_* outputs are 0, and we_o=0. ready_o=1 in the cycle after reset deasserts.
- IDLE: ready_o=1.
  - On valid_i, capture all *_i fields.
  - mem_op none → DONE.
  - load/store → REQ.
- REQ: dmem_req_valid_o=1. Address, wen, wdata and wstrb are held stable until dmem_req_ready_i=1, then → RESP. A request is never withdrawn before handshake.
- RESP: wait for dmem_resp_valid_i, then → DONE.
  - Load: capture extended data.
  - Store: response is the write ack; data is ignored.
  - A response is accepted no earlier than the cycle after the request handshake. dmem_resp_valid_i outside RESP is ignored.
- DONE: we_o=1 for exactly one cycle → IDLE. A new valid_i is not accepted in DONE.
- Latency, accept edge to we_o:
  - non-memory instruction: 1 cycle
  - zero-wait memory: 3 cycles
  - each bus stall adds 1 cycle
- Address: dmem_addr_o = {addr[31:2],2'b00}.
- Write strobes:
  - SB: 4'b0001<<addr[1:0]
  - SH: 4'b0011<<{addr[1],1'b0}
  - SW: 4'b1111
- Write data:
  - SB: byte replicated ×4
  - SH: halfword replicated ×2
  - SW: unchanged
- Load extraction:
  - LB/LBU select byte addr[1:0]; LH/LHU select halfword addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Reset in REQ/RESP: aborts immediately, drops the request, no we_o. A later stale response is ignored because state is IDLE.

Optional Feature:
- Macro MEM_MISALIGN_CHECK_EN.
- Enabled, misaligned accesses are:
  - LH/LHU/SH with addr[0]=1
  - LW/SW with addr[1:0]≠0
  Such an access issues no bus request and goes IDLE→DONE. wena_o is forced 0 and misalign_o=1 together with we_o.
- Disabled: misalign_o is tied 0. Low address bits beyond the access size are ignored (LW at 0x...3 reads the word at 0x...0).

Test Plan:
- Non-memory op, alu_result_i=0x12345678, wena_i=1, waddr_i=5 → we_o one cycle later, alu_result_o=0x12345678, mem_result_o=0, no dmem request.
- LB at 0x80000003, rdata=0x80FF0000, zero-wait → addr 0x80000000, mem_result_o=0xFFFFFF80, we_o 3 cycles after accept; LBU gives 0x00000080.
- SH at 0x80000006, store_data=0xAAAA1234, req_ready low 3 cycles → request stable throughout, wstrb=4'b1100, wdata=0x12341234, wen=1, we_o after ack.
- LW with resp delayed 5 cycles, valid_i held high → ready_o=0 until IDLE, second instruction accepted only after we_o.
- Reset asserted in RESP, then a stray resp_valid → no we_o, outputs 0, ready_o=1.
- With MEM_MISALIGN_CHECK_EN: LW at 0x80000002 → no dmem_req_valid_o, we_o=1, misalign_o=1, wena_o=0.
